// File: rtl/bitmap_scanout_scheduler_if.sv
// Host write handshake plus the single-port bitmap RAM bus of bitmap_scanout_scheduler.
// master = scheduler side, slave = host/RAM side.
interface bitmap_scanout_scheduler_if #(
    parameter int unsigned ADDR_W = 13
);
    logic              i_wr_valid;
    logic              o_wr_ready;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [15:0]       i_wr_data;
    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [15:0]       o_mem_wdata;
    logic [15:0]       i_mem_rdata;

    modport master (
        input  i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata,
        output o_wr_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport slave (
        output i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata,
        input  o_wr_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/bitmap_scanout_scheduler.sv
// Shares one bitmap RAM between 4bpp 160x120 scanout (x4 scale) and a host write port.
// Optional BITMAP_CLEAR_ON_RESET_EN zero-fills the visible bitmap after reset.
module bitmap_scanout_scheduler #(
    parameter int unsigned H_VISIBLE     = 640,
    parameter int unsigned H_TOTAL       = 800,
    parameter int unsigned V_VISIBLE     = 480,
    parameter int unsigned V_TOTAL       = 525,
    parameter int unsigned WORDS_PER_ROW = 40,
    parameter int unsigned ADDR_W        = 13
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [9:0]                i_hpos,
    input  logic [9:0]                i_vpos,
    input  logic                      i_visible,
    bitmap_scanout_scheduler_if.master bus,
    output logic [3:0]                o_pixel,
    output logic                      o_pixel_valid
);
    localparam int unsigned FB_WORDS = V_VISIBLE / 4 * WORDS_PER_ROW;

    typedef enum logic [1:0] {ST_INIT, ST_CLEAR, ST_RUN} state_t;

`ifdef BITMAP_CLEAR_ON_RESET_EN
    localparam state_t AFTER_INIT = ST_CLEAR;
`else
    localparam state_t AFTER_INIT = ST_RUN;
`endif

    state_t            state;
    logic [9:0]        next_vpos;
    logic              slot_line, slot_start, slot;
    logic              wr_take, clear_take, clear_done;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] line_base, start_base, mem_addr, addr_q, clear_addr;
    logic [15:0]       mem_wdata, wdata_q, cur_word, next_word;
    logic              fetch_d, started, primed;

    always_comb begin
        next_vpos  = (i_vpos == 10'(V_TOTAL - 1)) ? '0 : i_vpos + 10'd1;
        line_base  = ADDR_W'(32'(i_vpos[9:2]) * WORDS_PER_ROW);
        start_base = ADDR_W'(32'(next_vpos[9:2]) * WORDS_PER_ROW);
        slot_line  = (state != ST_INIT) && (i_vpos < 10'(V_VISIBLE)) &&
                     (i_hpos[3:0] == 4'd8) && (i_hpos < 10'(H_VISIBLE - 16));
        slot_start = (state != ST_INIT) && (i_hpos == 10'(H_TOTAL - 8)) &&
                     (next_vpos < 10'(V_VISIBLE));
        slot       = slot_line | slot_start;
    end

`ifdef BITMAP_CLEAR_ON_RESET_EN
    always_comb begin
        clear_take = (state == ST_CLEAR) && !slot;
        clear_done = clear_take && (clear_addr == ADDR_W'(FB_WORDS - 1));
    end
`else
    always_comb begin
        clear_take = 1'b0;
        clear_done = 1'b0;
        clear_addr = '0;
    end
`endif

    always_comb begin
        bus.o_wr_ready = (state == ST_RUN) && !slot;
        wr_take   = bus.i_wr_valid && bus.o_wr_ready && (bus.i_wr_addr < ADDR_W'(FB_WORDS));
        mem_en    = slot | wr_take | clear_take;
        mem_we    = !slot && (wr_take || clear_take);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (slot_line) begin
            mem_addr = line_base + ADDR_W'(i_hpos[9:4]) + ADDR_W'(1);
        end else if (slot_start) begin
            mem_addr = start_base;
        end else if (wr_take) begin
            mem_addr  = bus.i_wr_addr;
            mem_wdata = bus.i_wr_data;
        end else if (clear_take) begin
            mem_addr  = clear_addr;
            mem_wdata = '0;
        end
        bus.o_mem_en    = mem_en;
        bus.o_mem_we    = mem_we;
        bus.o_mem_addr  = mem_addr;
        bus.o_mem_wdata = mem_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_INIT;
            addr_q        <= '0;
            wdata_q       <= '0;
            fetch_d       <= 1'b0;
            started       <= 1'b0;
            primed        <= 1'b0;
            cur_word      <= '0;
            next_word     <= '0;
            o_pixel       <= '0;
            o_pixel_valid <= 1'b0;
`ifdef BITMAP_CLEAR_ON_RESET_EN
            clear_addr    <= '0;
`endif
        end else begin
            case (state)
                ST_INIT:  state <= AFTER_INIT;
                ST_CLEAR: if (clear_done) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
`ifdef BITMAP_CLEAR_ON_RESET_EN
            if (clear_take) clear_addr <= clear_addr + ADDR_W'(1);
`endif
            if (mem_en) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            fetch_d <= slot;
            if (fetch_d) next_word <= bus.i_mem_rdata;
            if ((i_hpos[3:0] == 4'hF) || (i_hpos == 10'(H_TOTAL - 1))) cur_word <= next_word;
            // In-line fetches resume right after reset, but pixels stay blank until a whole line was fetched from its start.
            if (slot_start) started <= 1'b1;
            if (started && (i_hpos == 10'(H_TOTAL - 1))) primed <= 1'b1;
            o_pixel       <= (i_visible && primed) ? cur_word[{i_hpos[3:2], 2'b00} +: 4] : '0;
            o_pixel_valid <= i_visible;
        end
    end
endmodule

// File: tb/tb_bitmap_scanout_scheduler.sv
// Directed bench for bitmap_scanout_scheduler with a frame-level reference model and RAM model.
module tb_bitmap_scanout_scheduler;
    localparam int unsigned ADDR_W = 13;
`ifdef BITMAP_CLEAR_ON_RESET_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic       visible = 1'b0;
    logic [3:0] pixel;
    logic       pixel_valid;
    logic       preload = 1'b0;

    int checks = 0;
    int errors = 0;

    bitmap_scanout_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    bitmap_scanout_scheduler #(.ADDR_W(ADDR_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_hpos       (hpos),
        .i_vpos       (vpos),
        .i_visible    (visible),
        .bus          (bus),
        .o_pixel      (pixel),
        .o_pixel_valid(pixel_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input int i);
        if (i == 0) return 16'h4321;
        if (i == 1) return 16'h8765;
        return 16'(i * 40503 + 12345);
    endfunction

    function automatic int nib(input logic [15:0] w, input int n);
        logic [15:0] t;
        t = w >> (4 * n);
        return int'(t[3:0]);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t h=%0d v=%0d)", name, act, exp, $time, hpos, vpos);
        end
    endtask

    // RAM: read data valid one cycle after the strobe.
    logic [15:0] ram [0:8191];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4800; i++) ram[i] <= pat(i);
        end else if (bus.o_mem_en) begin
            if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
            else              bus.i_mem_rdata <= ram[bus.o_mem_addr];
        end
    end

    // Reference model: image contents, expected strobes, expected pixel stream.
    logic [15:0] img [0:4799];
    int  mode = 0;          // 0 idle after reset, 1 clearing, 2 running
    int  clr_cnt = 0;
    int  clr_seen = 0;
    int  last_addr = 0;
    int  last_wdata = 0;
    int  exp_pix = 0;
    int  exp_pv = 0;
    bit  pend = 1'b0;
    bit  primed_m = 1'b0;

    always @(negedge clk) begin
        int h, v, nv, addr, wa;
        bit sl, ss, rdy, wrm, clr, en, we;
        h = int'(hpos);
        v = int'(vpos);
        if (!rst_n) begin
            chk("rst_mem_en", int'(bus.o_mem_en), 0);
            chk("rst_mem_we", int'(bus.o_mem_we), 0);
            chk("rst_mem_addr", int'(bus.o_mem_addr), 0);
            chk("rst_mem_wdata", int'(bus.o_mem_wdata), 0);
            chk("rst_wr_ready", int'(bus.o_wr_ready), 0);
            chk("rst_pixel", int'(pixel), 0);
            chk("rst_pixel_valid", int'(pixel_valid), 0);
            mode = 0; clr_cnt = 0; last_addr = 0; last_wdata = 0;
            exp_pix = 0; exp_pv = 0; pend = 1'b0; primed_m = 1'b0;
        end else begin
            chk("pixel", int'(pixel), exp_pix);
            chk("pixel_valid", int'(pixel_valid), exp_pv);
            nv  = (v == 524) ? 0 : v + 1;
            sl  = (mode != 0) && (v < 480) && (h % 16 == 8) && (h < 624);
            ss  = (mode != 0) && (h == 792) && (nv < 480);
            rdy = (mode == 2) && !(sl || ss);
            wa  = int'(bus.i_wr_addr);
            wrm = bus.i_wr_valid && rdy && (wa < 4800);
            clr = (mode == 1) && !(sl || ss);
            en  = sl || ss || wrm || clr;
            we  = wrm || clr;
            if (sl)       addr = (v / 4) * 40 + h / 16 + 1;
            else if (ss)  addr = (nv / 4) * 40;
            else if (wrm) addr = wa;
            else if (clr) addr = clr_cnt;
            else          addr = last_addr;
            chk("mem_en", int'(bus.o_mem_en), int'(en));
            chk("mem_we", int'(bus.o_mem_we), int'(we));
            chk("wr_ready", int'(bus.o_wr_ready), int'(rdy));
            chk("mem_addr", int'(bus.o_mem_addr), addr);
            if (we) last_wdata = wrm ? int'(bus.i_wr_data) : 0;
            if (we || !en) chk("mem_wdata", int'(bus.o_mem_wdata), last_wdata);
            last_addr = addr;
            if (wrm) img[wa] = bus.i_wr_data;
            if (clr) begin
                img[clr_cnt] = '0;
                clr_cnt++;
            end
            if (bus.o_mem_en && bus.o_mem_we && !bus.o_wr_ready && bus.o_mem_wdata == 16'h0) clr_seen++;
            exp_pv  = int'(visible);
            exp_pix = (visible && primed_m) ? nib(img[(v / 4) * 40 + h / 16], (h / 4) % 4) : 0;
            if (ss) pend = 1'b1;
            if (h == 799 && pend) primed_m = 1'b1;
            if (mode == 0)                         mode = CLEAR_EN ? 1 : 2;
            else if (mode == 1 && clr_cnt == 4800) mode = 2;
        end
        if (preload) begin
            for (int i = 0; i < 4800; i++) img[i] = pat(i);
        end
    end

    task automatic step(input int h, input int v);
        @(posedge clk);
        #1;
        hpos    = 10'(h);
        vpos    = 10'(v);
        visible = (h < 640) && (v < 480);
    endtask

    task automatic sweep(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) step(h, v);
    endtask

    initial begin
        int lit [0:19];
        lit = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4, 5, 5, 5, 5};
        bus.i_wr_valid = 1'b0;
        bus.i_wr_addr  = '0;
        bus.i_wr_data  = '0;

        step(0, 490);
        step(1, 490);
        @(negedge clk);
        chk("reset_pixel_lit", int'(pixel), 0);
        chk("reset_en_lit", int'(bus.o_mem_en), 0);
        step(2, 490);
        rst_n = 1'b1;
`ifdef BITMAP_CLEAR_ON_RESET_EN
        sweep(490, 3, 799);
        for (int v = 491; v <= 496; v++) begin
            sweep(v, 0, 799);
            if (v == 493) chk("clear_ready_low", int'(bus.o_wr_ready), 0);
        end
        @(negedge clk);
        chk("clear_writes", clr_seen, 4800);
        chk("clear_ready_high", int'(bus.o_wr_ready), 1);
`else
        sweep(490, 3, 20);
`endif
        step(0, 497);
        preload = 1'b1;
        step(1, 497);
        preload = 1'b0;

        sweep(523, 700, 799);
        sweep(524, 0, 791);
        step(792, 524);
        @(negedge clk);
        chk("ls_v524_en", int'(bus.o_mem_en), 1);
        chk("ls_v524_addr", int'(bus.o_mem_addr), 0);
        sweep(524, 793, 799);

        // Line 0: literal pixel run plus host write arbitration.
        for (int h = 0; h <= 799; h++) begin
            step(h, 0);
            if (h == 8) begin
                bus.i_wr_valid = 1'b1;
                bus.i_wr_addr  = 13'd100;
                bus.i_wr_data  = 16'hBEEF;
            end else if (h == 10 || h == 21) begin
                bus.i_wr_valid = 1'b0;
            end else if (h == 20) begin
                bus.i_wr_valid = 1'b1;
                bus.i_wr_addr  = 13'd4800;
                bus.i_wr_data  = 16'h1234;
            end
            if (h >= 1 && h <= 20) begin
                @(negedge clk);
                chk("pix_line0", int'(pixel), lit[h - 1]);
                if (h == 8) begin
                    chk("slot8_ready", int'(bus.o_wr_ready), 0);
                    chk("slot8_we", int'(bus.o_mem_we), 0);
                    chk("slot8_addr", int'(bus.o_mem_addr), 1);
                end
                if (h == 9) begin
                    chk("wr9_ready", int'(bus.o_wr_ready), 1);
                    chk("wr9_we", int'(bus.o_mem_we), 1);
                    chk("wr9_addr", int'(bus.o_mem_addr), 100);
                    chk("wr9_data", int'(bus.o_mem_wdata), 16'hBEEF);
                end
                if (h == 20) begin
                    chk("oob_ready", int'(bus.o_wr_ready), 1);
                    chk("oob_en", int'(bus.o_mem_en), 0);
                    chk("oob_addr_hold", int'(bus.o_mem_addr), 100);
                end
            end
        end

        sweep(1, 0, 799);
        sweep(2, 0, 799);
        sweep(3, 0, 791);
        step(792, 3);
        @(negedge clk);
        chk("ls_v3_en", int'(bus.o_mem_en), 1);
        chk("ls_v3_we", int'(bus.o_mem_we), 0);
        chk("ls_v3_addr", int'(bus.o_mem_addr), 40);
        sweep(3, 793, 799);
        sweep(4, 0, 799);

        // Asynchronous reset in the middle of a visible line.
        sweep(5, 0, 299);
        step(300, 5);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_en", int'(bus.o_mem_en), 0);
        chk("async_rst_pixel", int'(pixel), 0);
        chk("async_rst_pv", int'(pixel_valid), 0);
        sweep(5, 301, 305);
        step(306, 5);
        rst_n = 1'b1;
        sweep(5, 307, 399);
        step(400, 5);
        @(negedge clk);
        chk("post_rst_pixel", int'(pixel), 0);
        chk("post_rst_pv", int'(pixel_valid), 1);
        sweep(5, 401, 799);
        sweep(6, 0, 799);
        step(0, 7);
        step(1, 7);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
